pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: PC_W, 3, program-counter width (matches the 8-entry instruction memory).
REQ-002 Parameter: LAST_ADDR, 3'd7, final instruction address; sequential fetch past it halts.
REQ-003 Parameter: CNT_W, 8, retired-instruction counter width.
REQ-004 Port: clk  input  1  single clock; all state on rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-low.
REQ-006 Port: start  input  1  one-cycle pulse; leaves IDLE and begins fetch at address 0.
REQ-007 Port: stall  input  1  hold current pc this cycle.
REQ-008 Port: jump  input  1  control-unit jump signal for the current instruction.
REQ-009 Port: branch  input  1  control-unit branch signal for the current instruction.
REQ-010 Port: zero_flag  input  1  ALU zero result for the current instruction.
REQ-011 Port: imm  input  7  instruction[6:0], signed branch offset.
REQ-012 Port: jump_target  input  PC_W  instruction[2:0], absolute jump address.
REQ-013 Port: pc  output  PC_W  address driven to the processor's pc input.
REQ-014 Port: pc_valid  output  1  high when pc holds an instruction to execute this cycle.
REQ-015 Port: redirect  output  1  registered; high for one cycle after a taken jump or branch.
REQ-016 Port: halted  output  1  high in HALT state.
REQ-017 Port: retired  output  CNT_W  count of instructions completed.

Function
REQ-018 FSM states: IDLE, RUN, HALT; encoding 2 bits.
REQ-019 IDLE: pc=0, pc_valid=0; start=1 -> RUN, pc stays 0.
REQ-020 RUN: pc_valid=1; each clock with stall=0 the current instruction retires and pc updates.
REQ-021 Next-pc priority: jump > (branch & zero_flag) > sequential.
REQ-022 Jump: next pc = jump_target.
REQ-023 Taken branch: next pc = (pc + 1 + sign_extend(imm)) truncated to PC_W bits (modulo 2^PC_W).
REQ-024 Sequential: next pc = pc + 1; if pc == LAST_ADDR and no jump/taken branch -> HALT, pc holds LAST_ADDR.
REQ-025 Jump/taken branch at LAST_ADDR redirects normally; no halt.
REQ-026 Branch with zero_flag=0 is sequential.
REQ-027 stall=1 in RUN: pc, retired, state unchanged; jump/branch/zero_flag ignored; redirect=0 next cycle.
REQ-028 retired increments by 1 per non-stalled RUN cycle, wraps at 2^CNT_W.
REQ-029 redirect asserted the cycle after a non-stalled RUN cycle with a jump or taken branch, else 0.
REQ-030 HALT: pc_valid=0, halted=1, pc frozen; start=1 -> RUN, pc=0, retired cleared.
REQ-031 start ignored in RUN.
REQ-032 Latency: pc update visible one clock after the deciding edge; no combinational path from inputs to pc.

Reset
REQ-033 rst=0 asynchronously forces IDLE, pc=0, pc_valid=0, redirect=0, halted=0, retired=0, including mid-RUN or mid-stall.
REQ-034 First active edge after rst deassertion evaluates from IDLE only.

Structure
REQ-035 Shared package holds the state encoding constants (IDLE/RUN/HALT) and the PC_W default.
REQ-036 One combinational sub-module next_pc_calc (pc, imm, jump_target, jump, branch, zero_flag -> next pc, take_redirect); the FSM and counters reside in pc_sequencer.

Verification
REQ-037 rst low, start pulse, 8 non-stalled cycles with no jump/branch -> pc 0..7, retired=8, then halted=1, pc=7.
REQ-038 At pc=2, branch=1, zero_flag=1, imm=7'h7E (-2) -> next pc=1, redirect=1 one cycle later; zero_flag=0 -> pc=3.
REQ-039 At pc=6, imm=7'h03 taken -> pc=(6+1+3) mod 8 = 2 (wrap-around).
REQ-040 At pc=4, jump=1 and taken branch together, jump_target=3'd1 -> pc=1 (jump priority).
REQ-041 At pc=5, stall=1 for 3 cycles with jump asserted -> pc stays 5, retired unchanged, redirect=0.
REQ-042 rst pulsed low between edges while in RUN at pc=3 -> immediately pc=0, IDLE, retired=0; start from HALT -> pc=0, retired=0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state encoding
// and the default program-counter width.
package pc_sequencer_pkg;

  localparam int PC_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/pc_sequencer_next_pc.sv
// Combinational next-pc selection: jump beats taken branch beats sequential.
module next_pc_calc
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] pc,
  input  logic [6:0]      imm,
  input  logic [PC_W-1:0] jump_target,
  input  logic            jump,
  input  logic            branch,
  input  logic            zero_flag,
  output logic [PC_W-1:0] next_pc,
  output logic            take_redirect
);

  logic [PC_W-1:0] w_imm_ext;
  logic [PC_W-1:0] w_seq_pc;
  logic            w_br_taken;

  // Sign-extend or truncate the offset to PC_W; the sum wraps modulo 2^PC_W.
  assign w_imm_ext  = PC_W'($signed(imm));
  assign w_seq_pc   = pc + PC_W'(1);
  assign w_br_taken = branch & zero_flag;

  always_comb begin
    next_pc       = w_seq_pc;
    take_redirect = 1'b0;
    if (jump) begin
      next_pc       = jump_target;
      take_redirect = 1'b1;
    end else if (w_br_taken) begin
      next_pc       = w_seq_pc + w_imm_ext;
      take_redirect = 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALT control, retired-instruction
// counter and one-cycle redirect flag around the next_pc_calc datapath.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter logic [PC_W-1:0] LAST_ADDR = 3'd7,
  parameter int              CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic             jump,
  input  logic             branch,
  input  logic             zero_flag,
  input  logic [6:0]       imm,
  input  logic [PC_W-1:0]  jump_target,
  output logic [PC_W-1:0]  pc,
  output logic             pc_valid,
  output logic             redirect,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state;
  logic [PC_W-1:0]  r_pc;
  logic             r_pc_valid;
  logic             r_redirect;
  logic             r_halted;
  logic [CNT_W-1:0] r_retired;

  logic [PC_W-1:0]  w_next_pc;
  logic             w_take;

  next_pc_calc #(.PC_W(PC_W)) u_next_pc (
    .pc            (r_pc),
    .imm           (imm),
    .jump_target   (jump_target),
    .jump          (jump),
    .branch        (branch),
    .zero_flag     (zero_flag),
    .next_pc       (w_next_pc),
    .take_redirect (w_take)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_pc       <= '0;
      r_pc_valid <= 1'b0;
      r_redirect <= 1'b0;
      r_halted   <= 1'b0;
      r_retired  <= '0;
    end else begin
      r_redirect <= 1'b0;
      case (r_state)
        IDLE, HALT: begin
          if (start) begin
            r_state    <= RUN;
            r_pc       <= '0;
            r_pc_valid <= 1'b1;
            r_halted   <= 1'b0;
            r_retired  <= '0;
          end
        end
        RUN: begin
          if (!stall) begin
            r_retired  <= r_retired + 1'b1;
            r_redirect <= w_take;
            // Falling off the end of the program halts with pc parked at LAST_ADDR.
            if (!w_take && (r_pc == LAST_ADDR)) begin
              r_state    <= HALT;
              r_pc_valid <= 1'b0;
              r_halted   <= 1'b1;
            end else begin
              r_pc <= w_next_pc;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_pc       <= '0;
          r_pc_valid <= 1'b0;
          r_halted   <= 1'b0;
        end
      endcase
    end
  end

  assign pc       = r_pc;
  assign pc_valid = r_pc_valid;
  assign redirect = r_redirect;
  assign halted   = r_halted;
  assign retired  = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer against a behavioural model.
module tb_pc_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stall;
  logic       jump;
  logic       branch;
  logic       zero_flag;
  logic [6:0] imm;
  logic [2:0] jump_target;
  logic [2:0] pc;
  logic       pc_valid;
  logic       redirect;
  logic       halted;
  logic [7:0] retired;

  int n_chk;
  int n_err;

  // Model: 0 = idle, 1 = running, 2 = halted
  int m_mode;
  int m_pc;
  int m_ret;
  int m_redir;

  pc_sequencer #(.PC_W(3), .LAST_ADDR(3'd7), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stall       (stall),
    .jump        (jump),
    .branch      (branch),
    .zero_flag   (zero_flag),
    .imm         (imm),
    .jump_target (jump_target),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .redirect    (redirect),
    .halted      (halted),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = 0;
    m_ret   = 0;
    m_redir = 0;
  endtask

  // One clock of the program-level behaviour, from the current input values.
  task automatic model_step();
    int simm;
    simm = imm[6] ? int'(imm) - 128 : int'(imm);
    if (m_mode != 1) begin
      m_redir = 0;
      if (start) begin
        m_mode = 1;
        m_pc   = 0;
        m_ret  = 0;
      end
    end else if (stall) begin
      m_redir = 0;
    end else begin
      m_ret = (m_ret + 1) % 256;
      if (jump) begin
        m_pc    = int'(jump_target);
        m_redir = 1;
      end else if (branch && zero_flag) begin
        m_pc    = (((m_pc + 1 + simm) % 8) + 8) % 8;
        m_redir = 1;
      end else begin
        m_redir = 0;
        if (m_pc == 7) m_mode = 2;
        else m_pc = m_pc + 1;
      end
    end
  endtask

  task automatic check_all(input string p);
    chk({p, "_pc"},       int'(pc),       m_pc);
    chk({p, "_pc_valid"}, int'(pc_valid), (m_mode == 1) ? 1 : 0);
    chk({p, "_redirect"}, int'(redirect), m_redir);
    chk({p, "_halted"},   int'(halted),   (m_mode == 2) ? 1 : 0);
    chk({p, "_retired"},  int'(retired),  m_ret);
  endtask

  // Called 1 time unit after an active edge; applies inputs, clocks once, checks.
  task automatic cyc(input string p, input logic s, input logic st, input logic j,
                     input logic b, input logic z, input logic [6:0] im, input logic [2:0] jt);
    start = s; stall = st; jump = j; branch = b; zero_flag = z;
    imm = im; jump_target = jt;
    model_step();
    @(posedge clk);
    #1;
    check_all(p);
  endtask

  // Asynchronous reset pulse placed between two active edges.
  task automatic rst_pulse(input string p);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all(p);
    #1 rst = 1'b1;
  endtask

  task automatic seq(input string p, input int n);
    for (int k = 0; k < n; k++) cyc(p, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 3'd0);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst = 1'b0; start = 1'b0; stall = 1'b0; jump = 1'b0; branch = 1'b0;
    zero_flag = 1'b0; imm = '0; jump_target = '0;
    model_reset();
    #12;
    check_all("reset");
    #1 rst = 1'b1;

    // Straight-line run to the end of the program
    cyc("start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 3'd0);
    chk("start_pc0", int'(pc), 0);
    seq("seq", 8);
    chk("run8_retired", int'(retired), 8);
    chk("run8_halted", int'(halted), 1);
    chk("run8_pc", int'(pc), 7);
    seq("halt_hold", 2);

    // Restart from HALT clears pc and counter
    cyc("restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 3'd0);
    chk("restart_ret", int'(retired), 0);
    seq("to2", 2);
    cyc("br_back", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'h7E, 3'd0);
    chk("br_back_pc", int'(pc), 1);
    chk("br_back_redir", int'(redirect), 1);
    seq("to2b", 1);
    chk("redir_clear", int'(redirect), 0);
    cyc("br_nt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7'h7E, 3'd0);
    chk("br_nt_pc", int'(pc), 3);
    seq("to6", 3);
    cyc("br_wrap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'h03, 3'd0);
    chk("br_wrap_pc", int'(pc), 2);
    seq("to4", 2);
    cyc("jmp_pri", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 7'h02, 3'd1);
    chk("jmp_pri_pc", int'(pc), 1);
    seq("to5", 4);
    for (int k = 0; k < 3; k++) cyc("stall", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 7'h01, 3'd2);
    chk("stall_pc", int'(pc), 5);
    chk("stall_redir", int'(redirect), 0);
    seq("to7", 2);
    cyc("jmp_last", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 3'd3);
    chk("jmp_last_pc", int'(pc), 3);
    chk("jmp_last_halt", int'(halted), 0);
    rst_pulse("rst_mid");
    seq("post_rst_idle", 1);

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 600; i++) begin
      cyc("rnd", ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 1)), 7'($urandom), 3'($urandom));
      if ($urandom_range(0, 79) == 0) rst_pulse("rnd_rst");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
